// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the parallel RGB LCD path (pixel clock domain).
// Active-area x/y/pix_req lead the hsync/vsync/de outputs by DELAY clocks.
module lcd_timing_gen #(
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BACK   = 43,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 12,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FRONT  = 8,
  parameter int unsigned DELAY    = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pix_req,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        sof,
  output logic        eol,
  output logic [7:0]  frame
);

  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;
  localparam int unsigned PW      = DELAY + 1;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HA_BEG  = H_SYNC + H_BACK;
  localparam int unsigned HA_END  = HA_BEG + H_ACTIVE;
  localparam int unsigned VA_BEG  = V_SYNC + V_BACK;
  localparam int unsigned VA_END  = VA_BEG + V_ACTIVE;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HA_BEG_W = HW'(HA_BEG);
  localparam logic [VW-1:0] VA_BEG_W = VW'(VA_BEG);
  localparam logic [HW-1:0] X_LAST   = HW'(H_ACTIVE - 1);
  localparam logic          POL      = SYNC_POL;

  // Elaboration-time legality checks on the configuration.
  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("lcd_timing_gen: H_TOTAL %0d exceeds 11-bit counter", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("lcd_timing_gen: V_TOTAL %0d exceeds 10-bit counter", V_TOTAL);
  end
  if (DELAY > 7) begin : g_delay_chk
    $error("lcd_timing_gen: DELAY %0d out of range 0..7", DELAY);
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          hs_c;
  logic          vs_c;
  logic          ha_c;
  logic          va_c;
  logic          act_c;
  logic [HW-1:0] x_c;
  logic [VW-1:0] y_c;

  logic [PW-1:0] hs_pipe;
  logic [PW-1:0] vs_pipe;
  logic [PW-1:0] de_pipe;

  // Position decode; every phase boundary is a pure function of the counters.
  always_comb begin
    h_wrap_c = (h_cnt == H_LAST);
    v_wrap_c = (v_cnt == V_LAST);
    hs_c     = (32'(h_cnt) < H_SYNC);
    vs_c     = (32'(v_cnt) < V_SYNC);
    ha_c     = (32'(h_cnt) >= HA_BEG) && (32'(h_cnt) < HA_END);
    va_c     = (32'(v_cnt) >= VA_BEG) && (32'(v_cnt) < VA_END);
    act_c    = ha_c && va_c;
    x_c      = h_cnt - HA_BEG_W;
    y_c      = v_cnt - VA_BEG_W;
  end

  // Pixel/line counters and frame count; frame steps on the v_cnt wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame <= '0;
    end else if (h_wrap_c) begin
      h_cnt <= '0;
      if (v_wrap_c) begin
        v_cnt <= '0;
        frame <= frame + 8'd1;
      end else begin
        v_cnt <= v_cnt + VW'(1);
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Stage 1: active-area address and line/frame markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_req <= 1'b0;
      x       <= '0;
      y       <= '0;
      sof     <= 1'b0;
      eol     <= 1'b0;
    end else begin
      pix_req <= act_c;
      x       <= act_c ? x_c : '0;
      y       <= act_c ? y_c : '0;
      sof     <= act_c && (x_c == '0) && (y_c == '0);
      eol     <= act_c && (x_c == X_LAST);
    end
  end

  // Sync pipeline: bit 0 is stage 1, bit DELAY drives the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_pipe <= {PW{~POL}};
      vs_pipe <= {PW{~POL}};
      de_pipe <= '0;
    end else begin
      hs_pipe <= PW'({hs_pipe, (hs_c ? POL : ~POL)});
      vs_pipe <= PW'({vs_pipe, (vs_c ? POL : ~POL)});
      de_pipe <= PW'({de_pipe, act_c});
    end
  end

  assign hsync = hs_pipe[DELAY];
  assign vsync = vs_pipe[DELAY];
  assign de    = de_pipe[DELAY];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: hand vectors, reset corner cases and random-length
// runs checked against a position-index model for five configurations.
module tb_lcd_timing_gen;

  localparam int NI = 5;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf, dly;
    int pol;
  } cfg_t;

  typedef struct {
    int pr, x, y, sof, eol, hsync, vsync, de, frame;
  } exp_t;

  typedef struct {
    int k;
    int pr, x, y, sof, eol, hsync, vsync, de, frame;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        hs_o  [NI];
  logic        vs_o  [NI];
  logic        de_o  [NI];
  logic        pr_o  [NI];
  logic        sof_o [NI];
  logic        eol_o [NI];
  logic [10:0] x_o   [NI];
  logic [9:0]  y_o   [NI];
  logic [7:0]  fr_o  [NI];

  cfg_t  cfgs [NI];
  string nm   [NI];
  int    k;
  int    n_checks;
  int    n_err;

  lcd_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                   .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
                   .DELAY(2), .SYNC_POL(1'b0)) u_s2 (
    .clk(clk), .rst(rst), .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]),
    .pix_req(pr_o[0]), .x(x_o[0]), .y(y_o[0]), .sof(sof_o[0]), .eol(eol_o[0]),
    .frame(fr_o[0]));

  lcd_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                   .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
                   .DELAY(0), .SYNC_POL(1'b0)) u_s0 (
    .clk(clk), .rst(rst), .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]),
    .pix_req(pr_o[1]), .x(x_o[1]), .y(y_o[1]), .sof(sof_o[1]), .eol(eol_o[1]),
    .frame(fr_o[1]));

  lcd_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                   .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
                   .DELAY(3), .SYNC_POL(1'b0)) u_s3 (
    .clk(clk), .rst(rst), .hsync(hs_o[2]), .vsync(vs_o[2]), .de(de_o[2]),
    .pix_req(pr_o[2]), .x(x_o[2]), .y(y_o[2]), .sof(sof_o[2]), .eol(eol_o[2]),
    .frame(fr_o[2]));

  lcd_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                   .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
                   .DELAY(2), .SYNC_POL(1'b1)) u_sp (
    .clk(clk), .rst(rst), .hsync(hs_o[3]), .vsync(vs_o[3]), .de(de_o[3]),
    .pix_req(pr_o[3]), .x(x_o[3]), .y(y_o[3]), .sof(sof_o[3]), .eol(eol_o[3]),
    .frame(fr_o[3]));

  lcd_timing_gen u_def (
    .clk(clk), .rst(rst), .hsync(hs_o[4]), .vsync(vs_o[4]), .de(de_o[4]),
    .pix_req(pr_o[4]), .x(x_o[4]), .y(y_o[4]), .sof(sof_o[4]), .eol(eol_o[4]),
    .frame(fr_o[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int in_active(cfg_t c, int h, int v);
    int hb0 = c.hs + c.hb;
    int vb0 = c.vs + c.vb;
    return (h >= hb0 && h < hb0 + c.ha && v >= vb0 && v < vb0 + c.va) ? 1 : 0;
  endfunction

  // Output state after k rising edges since reset release: stage 1 shows
  // raster position k-1, the pins show position k-1-DELAY.
  function automatic exp_t model(cfg_t c, int kk);
    exp_t e;
    int ht = c.hs + c.hb + c.ha + c.hf;
    int vt = c.vs + c.vb + c.va + c.vf;
    int p, q, h, v;
    e.pr = 0; e.x = 0; e.y = 0; e.sof = 0; e.eol = 0; e.de = 0;
    e.hsync = 1 - c.pol;
    e.vsync = 1 - c.pol;
    e.frame = (kk / (ht * vt)) % 256;
    if (kk > 0) begin
      p = kk - 1;
      h = p % ht;
      v = (p / ht) % vt;
      if (in_active(c, h, v) != 0) begin
        e.pr  = 1;
        e.x   = h - (c.hs + c.hb);
        e.y   = v - (c.vs + c.vb);
        e.sof = (e.x == 0 && e.y == 0) ? 1 : 0;
        e.eol = (e.x == c.ha - 1) ? 1 : 0;
      end
    end
    q = kk - 1 - c.dly;
    if (q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      e.hsync = (h < c.hs) ? c.pol : 1 - c.pol;
      e.vsync = (v < c.vs) ? c.pol : 1 - c.pol;
      e.de    = in_active(c, h, v);
    end
    return e;
  endfunction

  task automatic chk(int i, string what, int got, int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s.%s k=%0d got=%0d want=%0d", nm[i], what, k, got, want);
    end
  endtask

  task automatic chk_vals(int i, exp_t e);
    chk(i, "pix_req", int'(pr_o[i]),  e.pr);
    chk(i, "x",       int'(x_o[i]),   e.x);
    chk(i, "y",       int'(y_o[i]),   e.y);
    chk(i, "sof",     int'(sof_o[i]), e.sof);
    chk(i, "eol",     int'(eol_o[i]), e.eol);
    chk(i, "hsync",   int'(hs_o[i]),  e.hsync);
    chk(i, "vsync",   int'(vs_o[i]),  e.vsync);
    chk(i, "de",      int'(de_o[i]),  e.de);
    chk(i, "frame",   int'(fr_o[i]),  e.frame);
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) chk_vals(i, model(cfgs[i], k));
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  // Assert reset between edges, check reset state, release before an edge.
  task automatic do_reset(int hold);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    #1;
    check_all();
    repeat (hold) @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  vec_t vecs[$];
  exp_t ev;

  initial begin
    rst = 1'b0;
    k = 0;
    n_checks = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++)
      cfgs[i] = '{hs:2, hb:3, ha:8, hf:2, vs:1, vb:2, va:4, vf:1, dly:2, pol:0};
    cfgs[1].dly = 0;
    cfgs[2].dly = 3;
    cfgs[3].pol = 1;
    cfgs[4] = '{hs:4, hb:43, ha:480, hf:8, vs:4, vb:12, va:272, vf:8, dly:2, pol:0};
    nm = '{"s2", "s0", "s3", "sp", "def"};

    // Hand-computed vectors for the small config, DELAY=2, active-low sync.
    //               k    pr x  y  sof eol hs vs de fr
    vecs.push_back('{0,   0, 0, 0, 0,  0,  1, 1, 0, 0});
    vecs.push_back('{1,   0, 0, 0, 0,  0,  1, 1, 0, 0});
    vecs.push_back('{3,   0, 0, 0, 0,  0,  0, 0, 0, 0});
    vecs.push_back('{4,   0, 0, 0, 0,  0,  0, 0, 0, 0});
    vecs.push_back('{5,   0, 0, 0, 0,  0,  1, 0, 0, 0});
    vecs.push_back('{17,  0, 0, 0, 0,  0,  1, 0, 0, 0});
    vecs.push_back('{18,  0, 0, 0, 0,  0,  0, 1, 0, 0});
    vecs.push_back('{51,  1, 0, 0, 1,  0,  1, 1, 0, 0});
    vecs.push_back('{53,  1, 2, 0, 0,  0,  1, 1, 1, 0});
    vecs.push_back('{58,  1, 7, 0, 0,  1,  1, 1, 1, 0});
    vecs.push_back('{59,  0, 0, 0, 0,  0,  1, 1, 1, 0});
    vecs.push_back('{61,  0, 0, 0, 0,  0,  1, 1, 0, 0});
    vecs.push_back('{66,  1, 0, 1, 0,  0,  1, 1, 0, 0});
    vecs.push_back('{112, 0, 0, 0, 0,  0,  1, 1, 0, 0});
    vecs.push_back('{119, 0, 0, 0, 0,  0,  1, 1, 0, 0});
    vecs.push_back('{120, 0, 0, 0, 0,  0,  1, 1, 0, 1});
    vecs.push_back('{123, 0, 0, 0, 0,  0,  0, 0, 0, 1});
    vecs.push_back('{171, 1, 0, 0, 1,  0,  1, 1, 0, 1});
    vecs.push_back('{240, 0, 0, 0, 0,  0,  1, 1, 0, 2});

    do_reset(2);
    foreach (vecs[j]) begin
      while (k < vecs[j].k) step();
      ev = '{pr:vecs[j].pr, x:vecs[j].x, y:vecs[j].y, sof:vecs[j].sof,
             eol:vecs[j].eol, hsync:vecs[j].hsync, vsync:vecs[j].vsync,
             de:vecs[j].de, frame:vecs[j].frame};
      chk_vals(0, ev);
    end

    // Mid-line reset at h_cnt=10, v_cnt=4 of the second frame.
    do_reset(1);
    while (k < 190) begin
      step();
      check_all();
    end
    ev = '{pr:1, x:4, y:1, sof:0, eol:0, hsync:1, vsync:1, de:1, frame:1};
    chk_vals(0, ev);
    rst = 1'b0;
    k = 0;
    #1;
    ev = '{pr:0, x:0, y:0, sof:0, eol:0, hsync:1, vsync:1, de:0, frame:0};
    chk_vals(0, ev);
    chk_vals(3, '{pr:0, x:0, y:0, sof:0, eol:0, hsync:0, vsync:0, de:0, frame:0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_vals(0, ev);
    rst = 1'b1;
    step();
    chk_vals(0, ev);
    step();
    step();
    chk_vals(0, '{pr:0, x:0, y:0, sof:0, eol:0, hsync:0, vsync:0, de:0, frame:0});
    chk_vals(1, '{pr:0, x:0, y:0, sof:0, eol:0, hsync:1, vsync:0, de:0, frame:0});

    // Random reset hold lengths and run lengths, checked every clock.
    for (int r = 0; r < 6; r++) begin
      do_reset(int'($urandom_range(1, 4)));
      repeat (int'($urandom_range(20, 300))) begin
        step();
        check_all();
      end
    end

    // Long run: many small frames and the first active lines of the default raster.
    do_reset(2);
    repeat (16 * 535 + 120) begin
      step();
      check_all();
      if (k == 16 * 535 + 47 + 1 + 1) chk(4, "first_de_pre", int'(de_o[4]), 0);
      if (k == 16 * 535 + 47 + 1 + 2) chk(4, "first_de", int'(de_o[4]), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
